// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for one stepper axis: direction setup, step high and step low phases, signed position.
// Optional macro STEP_GEN_MISS_CNT_EN builds a saturating counter of requests dropped while busy.
module step_pulse_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             step_req,
   input  logic             step_dir,
   input  logic [CNT_W-1:0] dir_setup,
   input  logic [CNT_W-1:0] step_high,
   input  logic [CNT_W-1:0] step_low,
   input  logic             pos_set,
   input  logic [31:0]      pos_set_val,
   output logic             ready,
   output logic             step_out,
   output logic             dir_out,
   output logic             step_done,
   output logic [31:0]      position,
   output logic [15:0]      missed
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIR_SETUP,
      S_HIGH,
      S_LOW
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] dir_setup_q, step_high_q, step_low_q;
   logic             accept, dir_chg, rise, fall, done;

   assign ready = (state == S_IDLE);

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_nxt = state;
      accept    = 1'b0;
      dir_chg   = 1'b0;
      rise      = 1'b0;
      fall      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (step_req) begin
               accept = 1'b1;
               if (step_dir != dir_out) begin
                  dir_chg   = 1'b1;
                  state_nxt = S_DIR_SETUP;
               end else begin
                  rise      = 1'b1;
                  state_nxt = S_HIGH;
               end
            end
         end
         S_DIR_SETUP: begin
            if (timer >= dir_setup_q) begin
               rise      = 1'b1;
               state_nxt = S_HIGH;
            end
         end
         S_HIGH: begin
            if (timer >= step_high_q) begin
               fall      = 1'b1;
               state_nxt = S_LOW;
            end
         end
         S_LOW: begin
            if (timer >= step_low_q) begin
               done      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer       <= '0;
         dir_setup_q <= '0;
         step_high_q <= '0;
         step_low_q  <= '0;
         step_out    <= 1'b0;
         dir_out     <= 1'b0;
         step_done   <= 1'b0;
         position    <= '0;
      end else begin
         // Timer restarts on every phase entry and rests at zero while idle.
         if (state_nxt != state || state == S_IDLE) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end

         if (accept) begin
            dir_setup_q <= dir_setup;
            step_high_q <= step_high;
            step_low_q  <= step_low;
         end

         if (dir_chg) begin
            dir_out <= step_dir;
         end

         if (rise) begin
            step_out <= 1'b1;
         end else if (fall) begin
            step_out <= 1'b0;
         end

         step_done <= done;

         // A position load overrides a coincident step update.
         if (pos_set) begin
            position <= pos_set_val;
         end else if (fall) begin
            position <= dir_out ? position + 32'd1 : position - 32'd1;
         end
      end
   end

`ifdef STEP_GEN_MISS_CNT_EN
   logic [15:0] missed_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         missed_q <= '0;
      end else if (step_req && !ready && missed_q != 16'hFFFF) begin
         missed_q <= missed_q + 16'd1;
      end
   end

   assign missed = missed_q;
`else
   assign missed = '0;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: phase timing, direction change, pulse train, miss counting,
// position load and asynchronous reset mid-step.
module tb_step_pulse_gen;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             step_req;
   logic             step_dir;
   logic [CNT_W-1:0] dir_setup;
   logic [CNT_W-1:0] step_high;
   logic [CNT_W-1:0] step_low;
   logic             pos_set;
   logic [31:0]      pos_set_val;
   logic             ready;
   logic             step_out;
   logic             dir_out;
   logic             step_done;
   logic [31:0]      position;
   logic [15:0]      missed;

   int n_checks = 0;
   int n_pass   = 0;

   step_pulse_gen #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .step_req    (step_req),
      .step_dir    (step_dir),
      .dir_setup   (dir_setup),
      .step_high   (step_high),
      .step_low    (step_low),
      .pos_set     (pos_set),
      .pos_set_val (pos_set_val),
      .ready       (ready),
      .step_out    (step_out),
      .dir_out     (dir_out),
      .step_done   (step_done),
      .position    (position),
      .missed      (missed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one request and reports, in negedge samples after the request edge E (k=0 is after E),
   // when step_out rose, when it fell and when step_done appeared. Fields are zeroed mid-step to
   // show the in-flight step uses its latched copies.
   task automatic measure_step(input logic d, output int k_rise, output int k_fall,
                               output int k_done, output logic [31:0] pos_at_fall);
      logic [CNT_W-1:0] ds, sh, sl;
      k_rise      = -1;
      k_fall      = -1;
      k_done      = -1;
      pos_at_fall = '0;
      ds = dir_setup;
      sh = step_high;
      sl = step_low;
      @(negedge clk);
      step_dir = d;
      step_req = 1'b1;
      @(negedge clk);
      step_req  = 1'b0;
      dir_setup = '0;
      step_high = '0;
      step_low  = '0;
      for (int k = 0; k < 64; k++) begin
         if (k > 0) @(negedge clk);
         if (k_rise < 0 && step_out) begin
            k_rise = k;
         end else if (k_rise >= 0 && k_fall < 0 && !step_out) begin
            k_fall      = k;
            pos_at_fall = position;
         end
         if (step_done) begin
            k_done = k;
            break;
         end
      end
      dir_setup = ds;
      step_high = sh;
      step_low  = sl;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 64; i++) begin
         if (ready) break;
         @(negedge clk);
      end
      check(tag, 32'(ready), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int          kr, kf, kd;
      logic [31:0] pf;
      int          issued, rises, bad_gap, last_rise;
      logic        prev_out;
      logic [15:0] m0;
      int          exp_miss;

      reset_n     = 1'b0;
      step_req    = 1'b0;
      step_dir    = 1'b0;
      dir_setup   = '0;
      step_high   = '0;
      step_low    = '0;
      pos_set     = 1'b0;
      pos_set_val = '0;
      repeat (3) @(negedge clk);
      check("rst_ready",    32'(ready),     32'd1);
      check("rst_step_out", 32'(step_out),  32'd0);
      check("rst_dir_out",  32'(dir_out),   32'd0);
      check("rst_done",     32'(step_done), 32'd0);
      check("rst_position", position,       32'd0);
      check("rst_missed",   32'(missed),    32'd0);
      reset_n = 1'b1;

      // Same direction: rise after E, fall at E+4, done after E+7.
      dir_setup = 16'd5;
      step_high = 16'd3;
      step_low  = 16'd2;
      measure_step(1'b0, kr, kf, kd, pf);
      check("same_rise",    32'(kr), 32'd0);
      check("same_fall",    32'(kf), 32'd4);
      check("same_done",    32'(kd), 32'd7);
      check("same_pos",     pf, 32'hFFFF_FFFF);
      check("same_dir_out", 32'(dir_out), 32'd0);
      check("same_ready",   32'(ready), 32'd1);
      @(negedge clk);
      check("same_done_1cyc", 32'(step_done), 32'd0);

      // Direction change: rise at E+6, fall at E+10, done after E+13.
      measure_step(1'b1, kr, kf, kd, pf);
      check("dirchg_rise",    32'(kr), 32'd6);
      check("dirchg_fall",    32'(kf), 32'd10);
      check("dirchg_done",    32'(kd), 32'd13);
      check("dirchg_pos",     pf, 32'd0);
      check("dirchg_dir_out", 32'(dir_out), 32'd1);

      // Pulse train with all fields 0, each follow-up request raised while step_done is high.
      dir_setup = '0;
      step_high = '0;
      step_low  = '0;
      issued    = 1;
      rises     = 0;
      bad_gap   = 0;
      last_rise = -1;
      prev_out  = 1'b0;
      @(negedge clk);
      step_dir = 1'b1;
      step_req = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (step_out && !prev_out) begin
            if (last_rise >= 0 && c - last_rise != 3) bad_gap++;
            last_rise = c;
            rises++;
         end
         prev_out = step_out;
         if (step_done && issued < 10) begin
            step_req = 1'b1;
            issued++;
         end else begin
            step_req = 1'b0;
         end
      end
      check("train_pulses",  32'(rises),   32'd10);
      check("train_period",  32'(bad_gap), 32'd0);
      check("train_pos",     position,     32'd10);
      check("train_missed",  32'(missed),  32'd0);

      // Request held for 20 edges with step_high=7: two accepted, 9 dropped during each.
      step_high = 16'd7;
      m0 = missed;
      @(negedge clk);
      step_req = 1'b1;
      repeat (20) @(negedge clk);
      step_req = 1'b0;
      wait_ready("miss_drain");
`ifdef STEP_GEN_MISS_CNT_EN
      exp_miss = 18;
`else
      exp_miss = 0;
`endif
      check("miss_count", 32'(missed - m0), 32'(exp_miss));
      check("miss_pos",   position,         32'd12);

      // Load near the positive limit, then one + step wraps.
      step_high = '0;
      @(negedge clk);
      pos_set     = 1'b1;
      pos_set_val = 32'h7FFF_FFFF;
      @(negedge clk);
      pos_set = 1'b0;
      check("load_pos", position, 32'h7FFF_FFFF);
      measure_step(1'b1, kr, kf, kd, pf);
      check("wrap_pos", pf, 32'h8000_0000);

      // pos_set on the S_HIGH exit edge (E+3 with step_high=2) wins over the step update.
      step_high = 16'd2;
      @(negedge clk);
      step_dir = 1'b1;
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      repeat (2) @(negedge clk);
      pos_set     = 1'b1;
      pos_set_val = 32'h1234_5678;
      @(negedge clk);
      pos_set = 1'b0;
      check("setwin_fell", 32'(step_out), 32'd0);
      check("setwin_pos",  position,      32'h1234_5678);
      wait_ready("setwin_drain");
      @(negedge clk);
      check("setwin_hold", position, 32'h1234_5678);

      // Asynchronous reset while in S_HIGH.
      step_high = 16'd7;
      @(negedge clk);
      step_req = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      @(negedge clk);
      check("midrst_pre_high", 32'(step_out), 32'd1);
      reset_n = 1'b0;
      #1;
      check("midrst_step_out", 32'(step_out), 32'd0);
      check("midrst_position", position,      32'd0);
      check("midrst_ready",    32'(ready),    32'd1);
      check("midrst_dir_out",  32'(dir_out),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Next request after reset: dir change from 0, all fields 1.
      dir_setup = 16'd1;
      step_high = 16'd1;
      step_low  = 16'd1;
      measure_step(1'b1, kr, kf, kd, pf);
      check("post_rst_rise", 32'(kr), 32'd2);
      check("post_rst_fall", 32'(kf), 32'd4);
      check("post_rst_done", 32'(kd), 32'd6);
      check("post_rst_pos",  pf,      32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
